// File: rtl/psram_async_ctrl_if.sv
// Request/response port between the sample engine and the PSRAM controller.
interface psram_async_ctrl_if #(
    parameter int unsigned ADDR_W = 23,
    parameter int unsigned LEN_W  = 8
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [15:0]       req_wdata;
    logic [1:0]        req_be;
    logic [LEN_W-1:0]  req_len;
    logic              rd_valid;
    logic [15:0]       rd_data;
    logic              rd_last;
    logic              wr_done;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_be, req_len,
        input  req_ready, rd_valid, rd_data, rd_last, wr_done
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_be, req_len,
        output req_ready, rd_valid, rd_data, rd_last, wr_done
    );
endinterface

// File: rtl/psram_async_ctrl.sv
// Async-mode cellular PSRAM controller: single-word byte-lane writes and
// auto-incrementing read bursts with programmable wait states.
module psram_async_ctrl #(
    parameter int unsigned ADDR_W  = 23,
    parameter int unsigned RD_WAIT = 6,
    parameter int unsigned WR_WAIT = 6,
    parameter int unsigned LEN_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    psram_async_ctrl_if.slave bus,
    output logic              RamAdv,
    output logic              RamClk,
    output logic              RamCS,
    output logic              MemOE,
    output logic              MemWR,
    output logic              RamLB,
    output logic              RamUB,
    output logic [25:0]       MemAdr,
    inout  wire  [15:0]       MemDB
);
    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] RD_RELOAD = CNT_W'(RD_WAIT - 1);
    localparam logic [CNT_W-1:0] WR_RELOAD = CNT_W'(WR_WAIT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_WRITE,
        S_HOLD
    } state_t;

    // Active-low PSRAM strobes, kept together so they register as one bundle.
    typedef struct packed {
        logic adv;
        logic cs;
        logic oe;
        logic we;
        logic ub;
        logic lb;
    } ctrl_t;

    localparam ctrl_t CTRL_IDLE = 6'b111111;
    localparam ctrl_t CTRL_READ = 6'b000100;

    state_t             state_q, state_d;
    ctrl_t              ctrl_q, ctrl_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               db_oe_q, db_oe_d;
    logic [15:0]        db_out_q, db_out_d;
    logic [15:0]        rd_data_q, rd_data_d;
    logic               rd_valid_q, rd_valid_d;
    logic               rd_last_q, rd_last_d;
    logic               wr_done_q, wr_done_d;
    logic               ready_q, ready_d;

    // State, pin and response registers; reset parks every strobe inactive.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            ctrl_q     <= CTRL_IDLE;
            cnt_q      <= '0;
            addr_q     <= '0;
            len_q      <= '0;
            db_oe_q    <= 1'b0;
            db_out_q   <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            rd_last_q  <= 1'b0;
            wr_done_q  <= 1'b0;
            ready_q    <= 1'b1;
        end else begin
            state_q    <= state_d;
            ctrl_q     <= ctrl_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            len_q      <= len_d;
            db_oe_q    <= db_oe_d;
            db_out_q   <= db_out_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            rd_last_q  <= rd_last_d;
            wr_done_q  <= wr_done_d;
            ready_q    <= ready_d;
        end
    end

    // Next-state and next-pin logic; pins change on the same edge as the state.
    always_comb begin
        state_d    = state_q;
        ctrl_d     = ctrl_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        len_d      = len_q;
        db_oe_d    = db_oe_q;
        db_out_d   = db_out_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        rd_last_d  = 1'b0;
        wr_done_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                ctrl_d  = CTRL_IDLE;
                db_oe_d = 1'b0;
                if (bus.req_valid) begin
                    addr_d = bus.req_addr;
                    if (bus.req_write) begin
                        state_d  = S_WRITE;
                        cnt_d    = WR_RELOAD;
                        db_oe_d  = 1'b1;
                        db_out_d = bus.req_wdata;
                        ctrl_d   = '{adv: 1'b0, cs: 1'b0, oe: 1'b1, we: 1'b0,
                                     ub: ~bus.req_be[1], lb: ~bus.req_be[0]};
                    end else begin
                        state_d = S_READ;
                        cnt_d   = RD_RELOAD;
                        len_d   = bus.req_len;
                        ctrl_d  = CTRL_READ;
                    end
                end
            end
            S_READ: begin
                if (cnt_q == '0) begin
                    // Beat boundary: capture the bus, then either finish or move on.
                    rd_data_d  = MemDB;
                    rd_valid_d = 1'b1;
                    if (len_q == '0) begin
                        state_d   = S_IDLE;
                        ctrl_d    = CTRL_IDLE;
                        rd_last_d = 1'b1;
                    end else begin
                        len_d  = len_q - LEN_W'(1);
                        addr_d = addr_q + ADDR_W'(1);
                        cnt_d  = RD_RELOAD;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_WRITE: begin
                if (cnt_q == '0) begin
                    state_d   = S_HOLD;
                    ctrl_d    = CTRL_IDLE;
                    wr_done_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_HOLD: begin
                // Data hold after WE rises; bus released on the way to IDLE.
                state_d = S_IDLE;
                db_oe_d = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
                ctrl_d  = CTRL_IDLE;
                db_oe_d = 1'b0;
            end
        endcase

        ready_d = (state_d == S_IDLE);
    end

    assign bus.req_ready = ready_q;
    assign bus.rd_valid  = rd_valid_q;
    assign bus.rd_data   = rd_data_q;
    assign bus.rd_last   = rd_last_q;
    assign bus.wr_done   = wr_done_q;

    assign RamAdv = ctrl_q.adv;
    assign RamClk = 1'b0;
    assign RamCS  = ctrl_q.cs;
    assign MemOE  = ctrl_q.oe;
    assign MemWR  = ctrl_q.we;
    assign RamLB  = ctrl_q.lb;
    assign RamUB  = ctrl_q.ub;
    assign MemAdr = 26'(addr_q);
    assign MemDB  = db_oe_q ? db_out_q : 16'hzzzz;
endmodule

// File: tb/tb_psram_async_ctrl.sv
// Bench for psram_async_ctrl: cycle-accurate pin checks against a word-level
// memory reference, plus a behavioural PSRAM on the pins.
module tb_psram_async_ctrl;
    localparam int unsigned ADDR_W  = 23;
    localparam int unsigned RD_WAIT = 6;
    localparam int unsigned WR_WAIT = 6;
    localparam int unsigned LEN_W   = 8;
    localparam logic [15:0] PROBE    = 16'h5A5A;
    localparam logic [5:0]  CTRL_OFF = 6'b111111;
    localparam logic [5:0]  CTRL_RD  = 6'b000100;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic RamAdv, RamClk, RamCS, MemOE, MemWR, RamLB, RamUB;
    logic [25:0] MemAdr;
    wire  [15:0] MemDB;
    logic [5:0]  ctrl;
    logic        probe_en = 1'b1;
    logic [15:0] pin_rd = 16'h0;

    int errors = 0;
    int checks = 0;

    psram_async_ctrl_if #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) bus ();

    psram_async_ctrl #(
        .ADDR_W(ADDR_W), .RD_WAIT(RD_WAIT), .WR_WAIT(WR_WAIT), .LEN_W(LEN_W)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .RamAdv(RamAdv), .RamClk(RamClk), .RamCS(RamCS), .MemOE(MemOE),
        .MemWR(MemWR), .RamLB(RamLB), .RamUB(RamUB), .MemAdr(MemAdr), .MemDB(MemDB)
    );

    always #5 clk = ~clk;

    assign ctrl  = {RamAdv, RamCS, MemOE, MemWR, RamUB, RamLB};
    // PSRAM drives the bus while selected for read; otherwise an optional probe
    // pattern shows whether the controller has released the bus.
    assign MemDB = (!MemOE && !RamCS) ? pin_rd : (probe_en ? PROBE : 16'hzzzz);

    // Contents of the PSRAM as seen at the pins, and the expected contents.
    logic [15:0] pin_mem [int unsigned];
    logic [15:0] ref_mem [int unsigned];

    function automatic logic [15:0] dflt_word(input logic [ADDR_W-1:0] a);
        return a[15:0] ^ 16'hA5C3;
    endfunction

    function automatic logic [15:0] pin_word(input logic [ADDR_W-1:0] a);
        if (pin_mem.exists(32'(a))) return pin_mem[32'(a)];
        return dflt_word(a);
    endfunction

    function automatic logic [15:0] ref_word(input logic [ADDR_W-1:0] a);
        if (ref_mem.exists(32'(a))) return ref_mem[32'(a)];
        return dflt_word(a);
    endfunction

    task automatic ref_write(input logic [ADDR_W-1:0] a, input logic [15:0] d, input logic [1:0] lanes);
        logic [15:0] w;
        w = ref_word(a);
        if (lanes[0]) w[7:0]  = d[7:0];
        if (lanes[1]) w[15:8] = d[15:8];
        ref_mem[32'(a)] = w;
    endtask

    // Behavioural async PSRAM: latches data while WE/CS low, commits when released.
    logic                pend = 1'b0;
    logic [ADDR_W-1:0]   pend_a;
    logic [15:0]         pend_d;
    logic [1:0]          pend_lanes;
    always @(negedge clk) begin
        logic [15:0] w;
        if (!RamCS && !MemWR) begin
            pend       = 1'b1;
            pend_a     = ADDR_W'(MemAdr);
            pend_d     = MemDB;
            pend_lanes = {~RamUB, ~RamLB};
        end else if (pend) begin
            w = pin_word(pend_a);
            if (pend_lanes[0]) w[7:0]  = pend_d[7:0];
            if (pend_lanes[1]) w[15:8] = pend_d[15:8];
            pin_mem[32'(pend_a)] = w;
            pend = 1'b0;
        end
        pin_rd = pin_word(ADDR_W'(MemAdr));
    end

    task automatic scramble_req();
        bus.req_write = 1'($urandom);
        bus.req_addr  = ADDR_W'($urandom);
        bus.req_wdata = 16'($urandom);
        bus.req_be    = 2'($urandom);
        bus.req_len   = LEN_W'($urandom);
    endtask

    // Single write; caller is at a negedge with the controller idle.
    task automatic do_write(input logic [ADDR_W-1:0] a, input logic [15:0] d, input logic [1:0] lanes);
        logic [5:0] exp_ctrl;
        logic [2:0] exp_flags;
        checks++;
        if (bus.req_ready !== 1'b1) begin
            errors++; $display("FAIL wr_ready_pre got=%b exp=1", bus.req_ready);
        end
        bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_addr = a;
        bus.req_wdata = d; bus.req_be = lanes; bus.req_len = LEN_W'($urandom);
        probe_en = 1'b0;
        for (int n = 1; n <= int'(WR_WAIT) + 2; n++) begin
            @(negedge clk);
            if (n == 1) begin bus.req_valid = 1'b0; scramble_req(); end
            if (n == int'(WR_WAIT) + 2) begin probe_en = 1'b1; #1; end
            exp_ctrl  = (n <= int'(WR_WAIT)) ? {4'b0010, ~lanes[1], ~lanes[0]} : CTRL_OFF;
            exp_flags = {1'(n == int'(WR_WAIT) + 1), 1'(n == int'(WR_WAIT) + 2), 1'b0};
            checks++;
            if (ctrl !== exp_ctrl) begin
                errors++; $display("FAIL wr_ctrl cyc=%0d got=%b exp=%b", n, ctrl, exp_ctrl);
            end
            checks++;
            if ({bus.wr_done, bus.req_ready, bus.rd_valid} !== exp_flags) begin
                errors++; $display("FAIL wr_flags cyc=%0d got=%b exp=%b", n,
                                   {bus.wr_done, bus.req_ready, bus.rd_valid}, exp_flags);
            end
            checks++;
            if (MemDB !== ((n <= int'(WR_WAIT) + 1) ? d : PROBE)) begin
                errors++; $display("FAIL wr_bus cyc=%0d got=%h exp=%h", n, MemDB,
                                   (n <= int'(WR_WAIT) + 1) ? d : PROBE);
            end
            checks++;
            if (MemAdr !== 26'(a)) begin
                errors++; $display("FAIL wr_addr cyc=%0d got=%h exp=%h", n, MemAdr, 26'(a));
            end
        end
        ref_write(a, d, lanes);
    endtask

    // Read burst of len+1 beats; caller is at a negedge with the controller idle.
    task automatic do_read(input logic [ADDR_W-1:0] a, input logic [LEN_W-1:0] len);
        int unsigned total, beat, k;
        logic [ADDR_W-1:0] ea;
        total = (int'(len) + 1) * RD_WAIT + 1;
        checks++;
        if (bus.req_ready !== 1'b1) begin
            errors++; $display("FAIL rd_ready_pre got=%b exp=1", bus.req_ready);
        end
        bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_addr = a; bus.req_len = len;
        bus.req_wdata = 16'($urandom); bus.req_be = 2'($urandom);
        probe_en = 1'b0;
        for (int unsigned n = 1; n <= total; n++) begin
            @(negedge clk);
            if (n == 1) begin bus.req_valid = 1'b0; scramble_req(); end
            beat = (n - 1) / RD_WAIT;
            if (n < total) begin
                ea = a + ADDR_W'(beat);
                checks++;
                if (ctrl !== CTRL_RD || bus.req_ready !== 1'b0) begin
                    errors++; $display("FAIL rd_ctrl cyc=%0d got=%b/%b exp=%b/0", n, ctrl,
                                       bus.req_ready, CTRL_RD);
                end
                checks++;
                if (MemAdr !== 26'(ea)) begin
                    errors++; $display("FAIL rd_addr cyc=%0d got=%h exp=%h", n, MemAdr, 26'(ea));
                end
            end else begin
                checks++;
                if (ctrl !== CTRL_OFF || bus.req_ready !== 1'b1) begin
                    errors++; $display("FAIL rd_end cyc=%0d got=%b/%b exp=%b/1", n, ctrl,
                                       bus.req_ready, CTRL_OFF);
                end
            end
            if (n > 1 && (n - 1) % RD_WAIT == 0) begin
                k  = beat - 1;
                ea = a + ADDR_W'(k);
                checks++;
                if ({bus.rd_valid, bus.rd_last} !== {1'b1, 1'(k == int'(len))}) begin
                    errors++; $display("FAIL rd_beat cyc=%0d got=%b exp=%b", n,
                                       {bus.rd_valid, bus.rd_last}, {1'b1, 1'(k == int'(len))});
                end
                checks++;
                if (bus.rd_data !== ref_word(ea)) begin
                    errors++; $display("FAIL rd_data cyc=%0d got=%h exp=%h", n, bus.rd_data, ref_word(ea));
                end
            end else begin
                checks++;
                if ({bus.rd_valid, bus.rd_last, bus.wr_done} !== 3'b000) begin
                    errors++; $display("FAIL rd_quiet cyc=%0d got=%b exp=000", n,
                                       {bus.rd_valid, bus.rd_last, bus.wr_done});
                end
            end
        end
        probe_en = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (ctrl !== CTRL_OFF || RamClk !== 1'b0) begin
            errors++; $display("FAIL reset_ctrl got=%b clk=%b exp=%b clk=0", ctrl, RamClk, CTRL_OFF);
        end
        checks++;
        if (MemDB !== PROBE) begin
            errors++; $display("FAIL reset_bus got=%h exp=%h", MemDB, PROBE);
        end
        checks++;
        if (MemAdr !== 26'h0) begin
            errors++; $display("FAIL reset_addr got=%h exp=0", MemAdr);
        end
        checks++;
        if ({bus.rd_valid, bus.rd_last, bus.wr_done} !== 3'b000 || bus.rd_data !== 16'h0) begin
            errors++; $display("FAIL reset_resp got=%b/%h exp=000/0000",
                               {bus.rd_valid, bus.rd_last, bus.wr_done}, bus.rd_data);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.req_ready !== 1'b1) begin
            errors++; $display("FAIL reset_ready got=%b exp=1", bus.req_ready);
        end
    endtask

    task automatic test_write_basic();
        do_write(23'h000010, 16'hBEEF, 2'b11);
    endtask

    task automatic test_read_basic();
        do_read(23'h000010, 8'd0);
    endtask

    // Low-lane-only write followed immediately by a read (bus turnaround).
    task automatic test_byte_lane();
        do_write(23'h000010, 16'h1234, 2'b01);
        do_read(23'h000010, 8'd0);
        checks++;
        if (bus.rd_data !== 16'hBE34) begin
            errors++; $display("FAIL lane_merge got=%h exp=BE34", bus.rd_data);
        end
        @(negedge clk);
        do_write(23'h000011, 16'hCAFE, 2'b00);
        do_read(23'h000011, 8'd0);
    endtask

    task automatic test_burst_wrap();
        @(negedge clk);
        do_read(23'h7FFFFF, 8'd2);
    endtask

    // Second request held through a busy read is taken in the first ready cycle.
    task automatic test_back_to_back();
        logic [ADDR_W-1:0] a0, a1, ea;
        logic [5:0] exp_ctrl;
        a0 = 23'h000200 + ADDR_W'($urandom_range(0, 15));
        a1 = a0 + ADDR_W'(5);
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_addr = a0; bus.req_len = '0;
        probe_en = 1'b0;
        for (int n = 1; n <= 2 * int'(RD_WAIT) + 2; n++) begin
            @(negedge clk);
            if (n == 1) bus.req_addr = a1;
            if (n == int'(RD_WAIT) + 2) begin bus.req_valid = 1'b0; scramble_req(); end
            if (n == int'(RD_WAIT) + 1 || n == 2 * int'(RD_WAIT) + 2) begin
                ea = (n == int'(RD_WAIT) + 1) ? a0 : a1;
                checks++;
                if ({bus.rd_valid, bus.rd_last, bus.req_ready} !== 3'b111 || bus.rd_data !== ref_word(ea)) begin
                    errors++; $display("FAIL b2b_beat cyc=%0d got=%b/%h exp=111/%h", n,
                                       {bus.rd_valid, bus.rd_last, bus.req_ready}, bus.rd_data, ref_word(ea));
                end
            end else begin
                ea = (n <= int'(RD_WAIT)) ? a0 : a1;
                exp_ctrl = CTRL_RD;
                checks++;
                if (ctrl !== exp_ctrl || MemAdr !== 26'(ea) || bus.req_ready !== 1'b0) begin
                    errors++; $display("FAIL b2b_busy cyc=%0d got=%b/%h/%b exp=%b/%h/0", n,
                                       ctrl, MemAdr, bus.req_ready, exp_ctrl, 26'(ea));
                end
            end
        end
        probe_en = 1'b1;
    endtask

    task automatic test_reset_mid_write();
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_addr = 23'h000030;
        bus.req_wdata = 16'($urandom); bus.req_be = 2'b11;
        probe_en = 1'b0;
        @(negedge clk);
        bus.req_valid = 1'b0;
        repeat (2) @(negedge clk);
        #2;
        rst = 1'b1; probe_en = 1'b1;
        #1;
        checks++;
        if (ctrl !== CTRL_OFF || MemDB !== PROBE) begin
            errors++; $display("FAIL abort_pins got=%b/%h exp=%b/%h", ctrl, MemDB, CTRL_OFF, PROBE);
        end
        for (int n = 0; n < 4 + int'(WR_WAIT); n++) begin
            @(negedge clk);
            if (n == 3) rst = 1'b0;
            checks++;
            if (bus.wr_done !== 1'b0 || ctrl !== CTRL_OFF) begin
                errors++; $display("FAIL abort_quiet n=%0d got=%b/%b exp=0/%b", n, bus.wr_done, ctrl, CTRL_OFF);
            end
        end
        checks++;
        if (bus.req_ready !== 1'b1) begin
            errors++; $display("FAIL abort_ready got=%b exp=1", bus.req_ready);
        end
    endtask

    task automatic test_random();
        logic [ADDR_W-1:0] a;
        repeat (30) begin
            if ($urandom_range(0, 3) == 0) a = 23'h7FFFFC + ADDR_W'($urandom_range(0, 3));
            else                           a = 23'h000100 + ADDR_W'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 1) do_write(a, 16'($urandom), 2'($urandom));
            else                           do_read(a, LEN_W'($urandom_range(0, 3)));
            if ($urandom_range(0, 2) == 0) @(negedge clk);
        end
    endtask

    initial begin
        bus.req_valid = 1'b0;
        scramble_req();
        test_reset();
        test_write_basic();
        test_read_basic();
        test_byte_lane();
        test_burst_wrap();
        test_back_to_back();
        test_reset_mid_write();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end
endmodule
